// File: rtl/isp_awb_gray_world_if.sv
// Video stream bundle for the AWB stage: frame/line syncs, pixel valid and one RGB pixel.
// The producer drives through the master modport, the consumer reads through the slave one.
interface isp_awb_gray_world_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  vsync;
    logic                  hsync;
    logic                  href;
    logic [DATA_WIDTH-1:0] red;
    logic [DATA_WIDTH-1:0] green;
    logic [DATA_WIDTH-1:0] blue;

    modport master (output vsync, hsync, href, red, green, blue);
    modport slave  (input  vsync, hsync, href, red, green, blue);
endinterface

// File: rtl/isp_awb_gray_world.sv
// Gray-world auto white balance. Per-frame channel sums are divided during vertical blanking
// (restoring divider, one quotient bit per clock) to give red/blue gains relative to green.
// New gains are committed at the next frame start and applied to a 2-stage pixel pipeline.
// Optional feature macro: AWB_GAIN_LIMIT_EN clamps pending gains to [0.5x, 2.0x].
module isp_awb_gray_world #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SUM_WIDTH  = 32,
    parameter int unsigned GAIN_FRAC  = 8,
    parameter int unsigned GAIN_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    isp_awb_gray_world_if.slave  per,
    isp_awb_gray_world_if.master post,
    output logic [GAIN_W-1:0]    gain_r,
    output logic [GAIN_W-1:0]    gain_b,
    output logic                 awb_busy
);
    localparam int unsigned QW = SUM_WIDTH + GAIN_FRAC;
    localparam int unsigned CW = $clog2(QW);
    localparam int unsigned AW = SUM_WIDTH + 1;
    localparam int unsigned PW = DATA_WIDTH + GAIN_W;
    localparam int unsigned SW = PW - GAIN_FRAC;
    localparam logic [GAIN_W-1:0] GAIN_MAX   = '1;
    localparam logic [GAIN_W-1:0] UNITY      = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [QW-1:0]     GAIN_MAX_Q = QW'(GAIN_MAX);
    localparam logic [CW-1:0]     LAST_STEP  = CW'(QW - 1);

    typedef enum logic [1:0] {StIdle, StDivR, StDivB, StDone} state_e;

    state_e                state_q, state_d;
    logic                  vsync_q;
    logic [SUM_WIDTH-1:0]  sum_r_q, sum_g_q, sum_b_q;
    logic [SUM_WIDTH-1:0]  sum_r_d, sum_g_d, sum_b_d;
    logic [AW-1:0]         add_r, add_g, add_b;
    logic [SUM_WIDTH-1:0]  snap_r_q, snap_g_q, snap_b_q;
    logic [QW-1:0]         quo_q, quo_next;
    logic [SUM_WIDTH-1:0]  rem_q, rem_next, divisor;
    logic [AW-1:0]         rem_sh;
    logic                  q_bit;
    logic [CW-1:0]         cnt_q;
    logic [GAIN_W-1:0]     q_gain, res_r_q, res_b_q, pend_r_new, pend_b_new;
    logic [GAIN_W-1:0]     pend_r_q, pend_b_q, gain_r_q, gain_b_q;
    logic                  pend_valid_q;
    logic                  fall, rise, last, done;
    logic [PW-1:0]         prod_r_q, prod_b_q;
    logic [DATA_WIDTH-1:0] green1_q, red2_q, green2_q, blue2_q;
    logic [SW-1:0]         sh_r, sh_b;
    logic [2:0]            sync1_q, sync2_q;

`ifdef AWB_GAIN_LIMIT_EN
    localparam logic [GAIN_W-1:0] GAIN_LO = GAIN_W'(1 << (GAIN_FRAC - 1));
    localparam logic [GAIN_W-1:0] GAIN_HI = GAIN_W'(1 << (GAIN_FRAC + 1));
`endif

    function automatic logic [GAIN_W-1:0] limit_gain(input logic [GAIN_W-1:0] g);
`ifdef AWB_GAIN_LIMIT_EN
        if (g < GAIN_LO) return GAIN_LO;
        if (g > GAIN_HI) return GAIN_HI;
        return g;
`else
        return g;
`endif
    endfunction

    assign fall = vsync_q & ~per.vsync;
    assign rise = per.vsync & ~vsync_q;
    assign last = (cnt_q == LAST_STEP);
    assign done = (state_q == StDone);

    // Saturating accumulator next values.
    always_comb begin
        add_r   = {1'b0, sum_r_q} + AW'(per.red);
        add_g   = {1'b0, sum_g_q} + AW'(per.green);
        add_b   = {1'b0, sum_b_q} + AW'(per.blue);
        sum_r_d = add_r[SUM_WIDTH] ? '1 : add_r[SUM_WIDTH-1:0];
        sum_g_d = add_g[SUM_WIDTH] ? '1 : add_g[SUM_WIDTH-1:0];
        sum_b_d = add_b[SUM_WIDTH] ? '1 : add_b[SUM_WIDTH-1:0];
    end

    // One restoring-division step plus gain saturation of the completed quotient.
    always_comb begin
        divisor  = (state_q == StDivB) ? snap_b_q : snap_r_q;
        rem_sh   = {rem_q, quo_q[QW-1]};
        q_bit    = (rem_sh >= {1'b0, divisor});
        rem_next = q_bit ? SUM_WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[SUM_WIDTH-1:0];
        quo_next = {quo_q[QW-2:0], q_bit};
        q_gain   = ((divisor == '0) || (quo_next > GAIN_MAX_Q)) ? GAIN_MAX
                                                                : quo_next[GAIN_W-1:0];
        // A black green channel gives no reference; fall back to unity.
        pend_r_new = (snap_g_q == '0) ? UNITY : limit_gain(res_r_q);
        pend_b_new = (snap_g_q == '0) ? UNITY : limit_gain(res_b_q);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state: a frame end only starts a division from idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fall) state_d = StDivR;
            StDivR:  if (last) state_d = StDivB;
            StDivB:  if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Statistics, divider datapath, pending and committed gains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            snap_r_q     <= '0;
            snap_g_q     <= '0;
            snap_b_q     <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            res_r_q      <= '0;
            res_b_q      <= '0;
            pend_r_q     <= UNITY;
            pend_b_q     <= UNITY;
            pend_valid_q <= 1'b0;
            gain_r_q     <= UNITY;
            gain_b_q     <= UNITY;
        end else begin
            vsync_q <= per.vsync;
            if (fall) begin
                sum_r_q <= '0;
                sum_g_q <= '0;
                sum_b_q <= '0;
            end else if (per.vsync && per.href) begin
                sum_r_q <= sum_r_d;
                sum_g_q <= sum_g_d;
                sum_b_q <= sum_b_d;
            end
            case (state_q)
                StIdle: begin
                    if (fall) begin
                        snap_r_q <= sum_r_q;
                        snap_g_q <= sum_g_q;
                        snap_b_q <= sum_b_q;
                        quo_q    <= {sum_g_q, {GAIN_FRAC{1'b0}}};
                        rem_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StDivR: begin
                    if (last) begin
                        // Red done; reload the dividend for the blue pass.
                        res_r_q <= q_gain;
                        quo_q   <= {snap_g_q, {GAIN_FRAC{1'b0}}};
                        rem_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDivB: begin
                    quo_q <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) res_b_q <= q_gain;
                end
                StDone: begin
                    pend_r_q <= pend_r_new;
                    pend_b_q <= pend_b_new;
                end
                default: ;
            endcase
            // Result landing on the same edge as a frame start is committed straight away.
            if (rise && (pend_valid_q || done)) pend_valid_q <= 1'b0;
            else if (done)                      pend_valid_q <= 1'b1;
            if (rise && done) begin
                gain_r_q <= pend_r_new;
                gain_b_q <= pend_b_new;
            end else if (rise && pend_valid_q) begin
                gain_r_q <= pend_r_q;
                gain_b_q <= pend_b_q;
            end
        end
    end

    // Stage-2 scaling back to pixel range with saturation.
    always_comb begin
        sh_r = prod_r_q[PW-1:GAIN_FRAC];
        sh_b = prod_b_q[PW-1:GAIN_FRAC];
    end

    // Two-stage pixel and sync pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_q <= '0;
            prod_b_q <= '0;
            green1_q <= '0;
            red2_q   <= '0;
            green2_q <= '0;
            blue2_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            prod_r_q <= per.red * gain_r_q;
            prod_b_q <= per.blue * gain_b_q;
            green1_q <= per.green;
            red2_q   <= (|sh_r[SW-1:DATA_WIDTH]) ? '1 : sh_r[DATA_WIDTH-1:0];
            blue2_q  <= (|sh_b[SW-1:DATA_WIDTH]) ? '1 : sh_b[DATA_WIDTH-1:0];
            green2_q <= green1_q;
            sync1_q  <= {per.vsync, per.hsync, per.href};
            sync2_q  <= sync1_q;
        end
    end

    assign post.vsync = sync2_q[2];
    assign post.hsync = sync2_q[1];
    assign post.href  = sync2_q[0];
    assign post.red   = red2_q;
    assign post.green = green2_q;
    assign post.blue  = blue2_q;
    assign gain_r     = gain_r_q;
    assign gain_b     = gain_b_q;
    assign awb_busy   = (state_q != StIdle);
endmodule
